// File: rtl/bt_pipe_pkg.sv
// Shared definitions for the block-throttled pipe generator/checker family:
// FSM encoding, reference LFSR polynomial and counter-mode start value.
package bt_pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_STROBE   = 3'd2,
    ST_READ     = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  // Feedback taps of the 32-bit Fibonacci LFSR (bit indices XORed into bit 0).
  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 21;
  localparam int LFSR_TAP_C = 1;
  localparam int LFSR_TAP_D = 0;

  localparam logic [15:0] CNT_INIT = 16'h0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    logic fb;
    fb = cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D];
    return {cur[30:0], fb};
  endfunction

endpackage

// File: rtl/prbs16_ref.sv
// Reference word generator: LFSR or incrementing counter, reloaded on load
// and stepped on advance. The mode is captured at load time.
module prbs16_ref
  import bt_pipe_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        mode_i,
  input  logic        advance_i,
  output logic [15:0] word_o
);

  logic [31:0] lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mode_q, mode_d;

  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (load_i) begin
      lfsr_d = LFSR_SEED;
      cnt_d  = CNT_INIT;
      mode_d = mode_i;
    end else if (advance_i) begin
      // Both sequences step together; only the selected one is observed.
      lfsr_d = lfsr_next(lfsr_q);
      cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
      cnt_q  <= CNT_INIT;
      mode_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign word_o = mode_q ? cnt_q : lfsr_q[15:0];

endmodule

// File: rtl/bt_pipe_reader.sv
// Consuming end of the block-throttled pipe handshake: pulls num_blocks blocks
// of BLOCK_LEN words and checks each word against the reference sequence.
module bt_pipe_reader
  import bt_pipe_pkg::*;
#(
  parameter int          BLOCK_LEN = 256,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] num_blocks,
  input  logic        rd_ready,
  output logic        rd_blockstrobe,
  output logic        rd_read,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] error_count,
  output logic [31:0] word_count,
  output logic [2:0]  dbg_state
);

  // Handshake: rd_ready is sampled only while waiting for a block; once the
  // strobe is issued the block is committed and rd_read stays high for exactly
  // BLOCK_LEN cycles. rd_data for a read is valid the following cycle.

  localparam int BW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_LEN - 1);

  state_t         state_q, state_d;
  logic [15:0]    blocks_q, blocks_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           cmp_valid_q;
  logic [15:0]    error_q, error_d;
  logic [31:0]    words_q, words_d;
  logic           start_acc;
  logic [15:0]    ref_word;

  assign start_acc = (state_q == ST_IDLE) && start;

  prbs16_ref #(
    .LFSR_SEED (LFSR_SEED)
  ) u_ref (
    .clk       (clk),
    .reset     (reset),
    .load_i    (start_acc),
    .mode_i    (mode),
    .advance_i (cmp_valid_q),
    .word_o    (ref_word)
  );

  always_comb begin
    state_d  = state_q;
    blocks_d = blocks_q;
    beat_d   = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          blocks_d = num_blocks;
          beat_d   = '0;
          state_d  = (num_blocks == 16'd0) ? ST_FINISH : ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: if (rd_ready) state_d = ST_STROBE;
      ST_STROBE:   state_d = ST_READ;
      ST_READ: begin
        if (beat_q == LAST_BEAT) begin
          beat_d   = '0;
          blocks_d = blocks_q - 16'd1;
          state_d  = (blocks_q == 16'd1) ? ST_DRAIN : ST_WAIT_RDY;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ST_DRAIN:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    error_d = error_q;
    words_d = words_q;
    if (start_acc) begin
      error_d = '0;
      words_d = '0;
    end else if (cmp_valid_q) begin
      words_d = words_q + 32'd1;
      if ((rd_data != ref_word) && (error_q != 16'hFFFF)) error_d = error_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      blocks_q    <= '0;
      beat_q      <= '0;
      cmp_valid_q <= 1'b0;
      error_q     <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      blocks_q    <= blocks_d;
      beat_q      <= beat_d;
      cmp_valid_q <= (state_q == ST_READ);
      error_q     <= error_d;
      words_q     <= words_d;
    end
  end

  assign rd_blockstrobe = (state_q == ST_STROBE);
  assign rd_read        = (state_q == ST_READ);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_FINISH);
  assign error_count    = error_q;
  assign word_count     = words_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_bt_pipe_reader.sv
// Directed bench for bt_pipe_reader with a behavioural pipe source and
// handshake monitors; each scenario task checks its own results.
`timescale 1ns/1ps
module tb_bt_pipe_reader;

  localparam int          BLOCK_LEN = 256;
  localparam logic [31:0] SEED      = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] num_blocks = '0;
  logic        rd_ready = 1'b1;
  logic        rd_blockstrobe;
  logic        rd_read;
  logic [15:0] rd_data = '0;
  logic        busy;
  logic        done;
  logic [15:0] error_count;
  logic [31:0] word_count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  bt_pipe_reader #(.BLOCK_LEN(BLOCK_LEN), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_blocks(num_blocks),
    .rd_ready(rd_ready), .rd_blockstrobe(rd_blockstrobe), .rd_read(rd_read),
    .rd_data(rd_data), .busy(busy), .done(done), .error_count(error_count),
    .word_count(word_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- pipe source model ----------------
  logic [31:0] s_lfsr = SEED;
  logic [15:0] s_cnt = 16'h0001;
  logic        s_mode = 1'b0;
  int          s_idx = 0;
  int          corrupt_idx = -1;
  logic        src_zero = 1'b0;
  logic [15:0] src_w;

  always @(posedge clk) begin
    if (start && !busy && !reset) begin
      s_lfsr <= SEED;
      s_cnt  <= 16'h0001;
      s_mode <= mode;
      s_idx  <= 0;
    end else if (rd_read) begin
      src_w = s_mode ? s_cnt : s_lfsr[15:0];
      if (src_zero) src_w = 16'h0000;
      if (s_idx == corrupt_idx) src_w = 16'hDEAD;
      rd_data <= src_w;
      s_lfsr  <= {s_lfsr[30:0], s_lfsr[31] ^ s_lfsr[21] ^ s_lfsr[1] ^ s_lfsr[0]};
      s_cnt   <= s_cnt + 16'd1;
      s_idx   <= s_idx + 1;
    end
  end

  // ---------------- handshake monitors ----------------
  int n_strobe = 0, n_read = 0, n_done = 0, n_badrun = 0, run_len = 0;

  always @(negedge clk) begin
    if (rd_blockstrobe) n_strobe++;
    if (done) n_done++;
    if (rd_read) begin
      n_read++;
      run_len++;
    end else if (run_len != 0) begin
      if (run_len != BLOCK_LEN) n_badrun++;
      run_len = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic m, input logic [15:0] nb);
    @(negedge clk);
    mode = m;
    num_blocks = nb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles (actual done=%0b, required 1)", name, budget, done);
    end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rd_read, rd_blockstrobe} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: actual %b required 0000", {busy, done, rd_read, rd_blockstrobe});
    end
    checks++;
    if (error_count !== 16'h0000 || word_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_counts: actual ec=%h wc=%h required 0/0", error_count, word_count);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: actual %0d required 0", dbg_state);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lfsr_match();
    int s0, r0, d0, b0;
    s0 = n_strobe; r0 = n_read; d0 = n_done; b0 = n_badrun;
    corrupt_idx = -1;
    pulse_start(1'b0, 16'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL lfsr_busy: actual %b required 1", busy);
    end
    wait_done(2000, "lfsr_done");
    checks++;
    if (n_strobe - s0 != 3) begin
      errors++;
      $display("FAIL lfsr_strobes: actual %0d required 3", n_strobe - s0);
    end
    checks++;
    if (n_read - r0 != 768) begin
      errors++;
      $display("FAIL lfsr_reads: actual %0d required 768", n_read - r0);
    end
    checks++;
    if (n_done - d0 != 1) begin
      errors++;
      $display("FAIL lfsr_done_cnt: actual %0d required 1", n_done - d0);
    end
    checks++;
    if (word_count !== 32'd768 || error_count !== 16'd0) begin
      errors++;
      $display("FAIL lfsr_counts: actual wc=%0d ec=%0d required 768/0", word_count, error_count);
    end
    checks++;
    if (n_badrun != b0) begin
      errors++;
      $display("FAIL lfsr_runs: actual bad runs %0d required 0", n_badrun - b0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lfsr_idle: actual busy=%b required 0", busy);
    end
  endtask

  task automatic test_counter_error();
    corrupt_idx = 100;
    pulse_start(1'b1, 16'd2);
    wait_done(2000, "cnt_done");
    checks++;
    if (error_count !== 16'd1 || word_count !== 32'd512) begin
      errors++;
      $display("FAIL cnt_err_counts: actual ec=%0d wc=%0d required 1/512", error_count, word_count);
    end
    corrupt_idx = -1;
  endtask

  task automatic test_throttle();
    int s1, r1, b0, k;
    b0 = n_badrun;
    r1 = n_read;
    pulse_start(1'b0, 16'd2);
    k = 0;
    while (n_read - r1 < BLOCK_LEN && k < 1000) begin
      @(negedge clk);
      k++;
    end
    rd_ready = 1'b0;
    s1 = n_strobe;
    r1 = n_read;
    repeat (50) @(negedge clk);
    checks++;
    if (n_strobe != s1 || n_read != r1) begin
      errors++;
      $display("FAIL throttle_gap: actual strobes=%0d reads=%0d required 0/0", n_strobe - s1, n_read - r1);
    end
    checks++;
    if (busy !== 1'b1 || dbg_state !== 3'd1) begin
      errors++;
      $display("FAIL throttle_wait: actual busy=%b state=%0d required 1/1", busy, dbg_state);
    end
    rd_ready = 1'b1;
    wait_done(2000, "throttle_done");
    checks++;
    if (error_count !== 16'd0 || word_count !== 32'd512) begin
      errors++;
      $display("FAIL throttle_counts: actual ec=%0d wc=%0d required 0/512", error_count, word_count);
    end
    checks++;
    if (n_badrun != b0) begin
      errors++;
      $display("FAIL throttle_runs: actual bad runs %0d required 0", n_badrun - b0);
    end
  endtask

  task automatic test_zero_blocks();
    int s0, r0, lat;
    s0 = n_strobe; r0 = n_read;
    @(negedge clk);
    mode = 1'b0; num_blocks = 16'd0; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 10);
    checks++;
    if (!done || lat > 2) begin
      errors++;
      $display("FAIL zero_latency: actual %0d cycles required 1..2", lat);
    end
    @(negedge clk);
    checks++;
    if (n_strobe != s0 || n_read != r0 || error_count !== 16'd0 || word_count !== 32'd0) begin
      errors++;
      $display("FAIL zero_activity: actual strobes=%0d reads=%0d ec=%0d wc=%0d required 0/0/0/0",
               n_strobe - s0, n_read - r0, error_count, word_count);
    end
  endtask

  task automatic test_saturation();
    src_zero = 1'b1;
    pulse_start(1'b1, 16'd300);
    wait_done(80000, "sat_done");
    checks++;
    if (error_count !== 16'hFFFF || word_count !== 32'd76800) begin
      errors++;
      $display("FAIL saturation: actual ec=%h wc=%0d required FFFF/76800", error_count, word_count);
    end
    src_zero = 1'b0;
  endtask

  task automatic test_reset_restart();
    int d0, s0, k;
    pulse_start(1'b0, 16'd2);
    repeat (100) @(negedge clk);
    d0 = n_done;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, rd_read, rd_blockstrobe, done} !== 4'b0000 || word_count !== 32'd0) begin
      errors++;
      $display("FAIL abort_outputs: actual ctrl=%b wc=%0d required 0000/0", {busy, rd_read, rd_blockstrobe, done}, word_count);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (n_done != d0) begin
      errors++;
      $display("FAIL abort_no_done: actual %0d pulses required 0", n_done - d0);
    end
    s0 = n_strobe;
    pulse_start(1'b0, 16'd1);
    k = 0;
    while (!rd_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    // A start while busy must not relatch mode or block count.
    mode = 1'b1; num_blocks = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, "restart_done");
    checks++;
    if (error_count !== 16'd0 || word_count !== 32'd256) begin
      errors++;
      $display("FAIL restart_counts: actual ec=%0d wc=%0d required 0/256", error_count, word_count);
    end
    checks++;
    if (n_strobe - s0 != 1) begin
      errors++;
      $display("FAIL busy_start_ignored: actual strobes=%0d required 1", n_strobe - s0);
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_match();
    test_counter_error();
    test_throttle();
    test_zero_blocks();
    test_reset_restart();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
